io_port_ctrl: RTL and testbench
===============================

IO_PORT_CTRL -- requirements
Module: io_port_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data width of every port and of the CPU data bus.
REQ-002 The block SHALL have parameter NPORTS, default 4, meaning the number of input ports and the number of output ports.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, meaning the consecutive stall cycles before forced release.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 addr  input  2  CPU port select (log2 NPORTS).
REQ-007 re  input  1  CPU input-instruction strobe (read port addr).
REQ-008 we  input  1  CPU output-instruction strobe (write port addr).
REQ-009 wdata  input  WIDTH  CPU data to output port.
REQ-010 rdata  output  WIDTH  data returned to CPU register-file write path.
REQ-011 stall  output  1  high freezes CPU (drives PC register enable low, regfile we3 low).
REQ-012 err  output  1  sticky timeout flag.
REQ-013 in_data  input  NPORTS*WIDTH  external input data, port i at bits [i*WIDTH +: WIDTH].
REQ-014 in_valid / in_ready  input / output  NPORTS  external-to-block handshake per input port.
REQ-015 out_data  output  NPORTS*WIDTH  registered output data per port.
REQ-016 out_valid / out_ack  output / input  NPORTS  block-to-external handshake per output port.

Function
REQ-017 Each input port SHALL hold one WIDTH-bit holding register plus a full flag; in_ready[i] SHALL equal the registered value of !full[i].
REQ-018 On a posedge with in_valid[i] and in_ready[i] high, the block SHALL capture in_data port i and set full[i]; visible to CPU the next cycle.
REQ-019 With re high and full[addr] high, rdata SHALL combinationally equal holding[addr], stall SHALL be low, and full[addr] SHALL clear at that posedge.
REQ-020 With re high and full[addr] low, stall SHALL be high and rdata SHALL be 0.
REQ-021 A CPU read and an external capture SHALL NOT both affect the same port in one cycle (in_ready is low while full).
REQ-022 Each output port SHALL hold an out_data register and out_valid flag; out_valid[i] SHALL clear at a posedge where out_ack[i] is high.
REQ-023 With we high and (out_valid[addr] low or out_ack[addr] high), wdata SHALL load into out_data[addr] and out_valid[addr] SHALL be 1 after that posedge; stall from the write SHALL be low.
REQ-024 With we high, out_valid[addr] high and out_ack[addr] low, stall SHALL be high and out_data[addr] SHALL NOT change.
REQ-025 With re and we both high, each SHALL be serviced independently; stall SHALL be the OR of both stall conditions.
REQ-026 A watchdog counter SHALL increment each cycle stall is high and reset to 0 on any cycle stall is low.
REQ-027 When the counter equals TIMEOUT, stall SHALL be forced low for that cycle, a pending write SHALL be discarded, rdata SHALL be 0, err SHALL set, and the counter SHALL return to 0.
REQ-028 err SHALL remain set until reset.
REQ-029 With re and we both low, rdata SHALL be 0 and stall SHALL be low.

Reset
REQ-030 While reset is low, all full flags, out_valid, out_data, holding registers, the watchdog counter and err SHALL be 0, in_ready SHALL be all-ones, and stall SHALL be low, independent of clk.
REQ-031 Deassertion of reset mid-stall SHALL leave the CPU unstalled with no pending transaction retained.

Structure
REQ-032 WIDTH, NPORTS, TIMEOUT defaults and the port-address constants SHALL live in shared package io_pkg.
REQ-033 The per-port input holding register and full flag SHALL be one sub-module, io_in_slot, instantiated NPORTS times.

Verification
REQ-034 Reset release, in_valid[2]=1 with in_data port 2 = 0x5A, then re=1, addr=2 two cycles later -> rdata=0x5A, stall=0, in_ready[2] returns to 1 the next cycle.
REQ-035 re=1, addr=1 with port 1 empty for 3 cycles, then in_valid[1]=1 with 0x33 -> stall=1 for 4 cycles, then rdata=0x33 and stall=0.
REQ-036 we=1, addr=0, wdata=0xA5 -> out_data port 0 = 0xA5, out_valid[0]=1; second we with 0x11 and out_ack[0]=0 -> stall=1 until out_ack[0]=1, then out_data port 0 = 0x11.
REQ-037 re=1 on an empty port for 255 cycles -> stall released on cycle 255, err=1, rdata=0; err still 1 after 10 idle cycles.
REQ-038 Assert reset while stalled on a write -> out_valid=0, stall=0, err=0, watchdog counter=0 immediately, with no clk edge required.

Source files
------------

// File: rtl/io_pkg.sv
// Shared defaults and port-address constants for the CPU I/O port controller.
// Imported by io_in_slot and io_port_ctrl.
package io_pkg;

   localparam int IO_WIDTH   = 8;
   localparam int IO_NPORTS  = 4;
   localparam int IO_TIMEOUT = 255;

   localparam logic [1:0] PORT0 = 2'd0;
   localparam logic [1:0] PORT1 = 2'd1;
   localparam logic [1:0] PORT2 = 2'd2;
   localparam logic [1:0] PORT3 = 2'd3;

endpackage

// File: rtl/io_in_slot.sv
// One input port: a holding register plus a full flag.
// Ports: clk, reset (async, active-low), valid_i/data_i (external side),
// pop_i (CPU consumed), ready_o (= !full), full_o, data_o (held word).
module io_in_slot
   import io_pkg::*;
#(
   parameter int WIDTH = IO_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             ready_o,
   output logic             full_o,
   output logic [WIDTH-1:0] data_o
);

   logic             full_q, full_d;
   logic [WIDTH-1:0] hold_q, hold_d;

   // A pop only happens while full and a capture only while empty,
   // so the two never touch the slot in the same cycle.
   always_comb begin
      full_d = full_q;
      hold_d = hold_q;
      if (pop_i) begin
         full_d = 1'b0;
      end else if (valid_i && !full_q) begin
         full_d = 1'b1;
         hold_d = data_i;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         full_q <= 1'b0;
         hold_q <= '0;
      end else begin
         full_q <= full_d;
         hold_q <= hold_d;
      end
   end

   assign ready_o = !full_q;
   assign full_o  = full_q;
   assign data_o  = hold_q;

endmodule

// File: rtl/io_port_ctrl.sv
// CPU-side I/O port controller: blocking IN/OUT instructions with stall and watchdog.
// Ports: clk, reset (async low), addr/re/we/wdata/rdata/stall/err (CPU),
// in_data/in_valid/in_ready and out_data/out_valid/out_ack (external ports).
module io_port_ctrl
   import io_pkg::*;
#(
   parameter  int WIDTH   = IO_WIDTH,
   parameter  int NPORTS  = IO_NPORTS,
   parameter  int TIMEOUT = IO_TIMEOUT,
   localparam int AW      = $clog2(NPORTS),
   localparam int CW      = $clog2(TIMEOUT + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [AW-1:0]           addr,
   input  logic                    re,
   input  logic                    we,
   input  logic [WIDTH-1:0]        wdata,
   output logic [WIDTH-1:0]        rdata,
   output logic                    stall,
   output logic                    err,
   input  logic [NPORTS*WIDTH-1:0] in_data,
   input  logic [NPORTS-1:0]       in_valid,
   output logic [NPORTS-1:0]       in_ready,
   output logic [NPORTS*WIDTH-1:0] out_data,
   output logic [NPORTS-1:0]       out_valid,
   input  logic [NPORTS-1:0]       out_ack
);

   logic [NPORTS-1:0]            full;
   logic [NPORTS-1:0][WIDTH-1:0] hold;
   logic [NPORTS-1:0]            pop;

   logic [NPORTS-1:0][WIDTH-1:0] od_q, od_d;
   logic [NPORTS-1:0]            ov_q, ov_d;
   logic [CW-1:0]                wdog_q, wdog_d;
   logic                         err_q, err_d;

   logic rd_wait, wr_wait, tmo, rd_go, wr_go;

   for (genvar g = 0; g < NPORTS; g++) begin : g_in
      io_in_slot #(.WIDTH(WIDTH)) u_slot (
         .clk     (clk),
         .reset   (reset),
         .valid_i (in_valid[g]),
         .data_i  (in_data[g*WIDTH +: WIDTH]),
         .pop_i   (pop[g]),
         .ready_o (in_ready[g]),
         .full_o  (full[g]),
         .data_o  (hold[g])
      );
   end

   always_comb begin
      rd_wait = re && !full[addr];
      wr_wait = we && ov_q[addr] && !out_ack[addr];
      // Watchdog expiry only counts while something is still waiting.
      tmo     = (wdog_q == CW'(TIMEOUT)) && (rd_wait || wr_wait);
      rd_go   = re && full[addr] && !tmo;
      wr_go   = we && !wr_wait && !tmo;
      // Gated by reset so the CPU is released the instant reset drops.
      stall   = (rd_wait || wr_wait) && !tmo && reset;
      rdata   = rd_go ? hold[addr] : '0;

      pop = '0;
      if (rd_go) pop[addr] = 1'b1;

      ov_d = ov_q & ~out_ack;
      od_d = od_q;
      if (wr_go) begin
         ov_d[addr] = 1'b1;
         od_d[addr] = wdata;
      end

      wdog_d = stall ? wdog_q + 1'b1 : '0;
      err_d  = err_q || tmo;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         od_q   <= '0;
         ov_q   <= '0;
         wdog_q <= '0;
         err_q  <= 1'b0;
      end else begin
         od_q   <= od_d;
         ov_q   <= ov_d;
         wdog_q <= wdog_d;
         err_q  <= err_d;
      end
   end

   assign out_data  = od_q;
   assign out_valid = ov_q;
   assign err       = err_q;

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed bench for io_port_ctrl: reads, writes, stalls, watchdog, reset.
// Inputs change 1 time unit after posedge; outputs sampled 1 unit later.
module tb_io_port_ctrl;
   import io_pkg::*;

   logic        clk;
   logic        reset;
   logic [1:0]  addr;
   logic        re, we;
   logic [7:0]  wdata;
   logic [7:0]  rdata;
   logic        stall, err;
   logic [31:0] in_data;
   logic [3:0]  in_valid, in_ready;
   logic [31:0] out_data;
   logic [3:0]  out_valid, out_ack;

   int tests = 0;
   int fails = 0;
   int scnt;

   io_port_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .addr      (addr),
      .re        (re),
      .we        (we),
      .wdata     (wdata),
      .rdata     (rdata),
      .stall     (stall),
      .err       (err),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ack   (out_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; addr = '0; re = 0; we = 0; wdata = '0;
      in_data = '0; in_valid = '0; out_ack = '0;
      #3;
      chk("rst_in_ready", in_ready, 4'hF);
      chk("rst_stall", stall, 0);
      chk("rst_err", err, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_rdata", rdata, 0);
      #9 reset = 1'b1;

      // input capture on port 2, read two cycles later
      tick();
      in_valid = 4'b0100; in_data = 32'h005A_0000;
      tick();
      in_valid = '0; in_data = '0;
      #1 chk("cap_ready_low", in_ready[2], 0);
      tick();
      re = 1; addr = PORT2;
      #1 chk("rd2_rdata", rdata, 8'h5A);
      chk("rd2_stall", stall, 0);
      tick();
      re = 0;
      #1 chk("rd2_ready_back", in_ready[2], 1);
      chk("idle_rdata", rdata, 0);
      chk("idle_stall", stall, 0);

      // blocking read on empty port 1, data arrives on 4th cycle
      tick();
      re = 1; addr = PORT1; scnt = 0;
      #1;
      for (int i = 0; i < 3; i++) begin
         if (stall === 1'b1) scnt++;
         tick(); #1;
      end
      in_valid = 4'b0010; in_data = 32'h0000_3300;
      #1 if (stall === 1'b1) scnt++;
      chk("rd1_rdata_wait", rdata, 0);
      tick();
      in_valid = '0; in_data = '0;
      #1 chk("rd1_stall_cycles", scnt, 4);
      chk("rd1_rdata", rdata, 8'h33);
      chk("rd1_stall", stall, 0);
      tick();
      re = 0;

      // write port 0, then blocked second write until ack
      we = 1; addr = PORT0; wdata = 8'hA5;
      #1 chk("wr0_stall", stall, 0);
      tick();
      we = 0;
      #1 chk("wr0_data", out_data[7:0], 8'hA5);
      chk("wr0_valid", out_valid[0], 1);
      we = 1; wdata = 8'h11; scnt = 0;
      #1;
      for (int i = 0; i < 3; i++) begin
         if (stall === 1'b1) scnt++;
         tick(); #1;
      end
      chk("wr0b_stall_cycles", scnt, 3);
      chk("wr0b_hold", out_data[7:0], 8'hA5);
      out_ack = 4'b0001;
      #1 chk("wr0b_ack_stall", stall, 0);
      tick();
      we = 0; out_ack = '0;
      #1 chk("wr0b_data", out_data[7:0], 8'h11);
      chk("wr0b_valid", out_valid[0], 1);

      // simultaneous read (empty port 1) and write (free port 1)
      re = 1; we = 1; addr = PORT1; wdata = 8'hC3;
      #1 chk("both_stall", stall, 1);
      tick();
      re = 0; we = 0;
      #1 chk("both_wdata", out_data[15:8], 8'hC3);
      chk("both_valid", out_valid, 4'b0011);
      out_ack = 4'b0011;
      tick();
      out_ack = '0;
      #1 chk("ack_clear", out_valid, 4'b0000);

      // watchdog on empty port 3
      re = 1; addr = PORT3; scnt = 0;
      #1;
      for (int i = 0; i < 255; i++) begin
         if (stall === 1'b1) scnt++;
         tick(); #1;
      end
      chk("wd_stall_cycles", scnt, 255);
      chk("wd_count", dut.wdog_q, 255);
      chk("wd_release", stall, 0);
      chk("wd_rdata", rdata, 0);
      chk("wd_err_pre", err, 0);
      tick();
      re = 0;
      #1 chk("wd_err", err, 1);
      chk("wd_count_zero", dut.wdog_q, 0);
      for (int i = 0; i < 10; i++) tick();
      chk("wd_err_sticky", err, 1);

      // reset asserted while stalled on a write to port 2
      we = 1; addr = PORT2; wdata = 8'h77;
      tick();
      wdata = 8'h88;
      tick();
      tick();
      #1 chk("rs_stalled", stall, 1);
      chk("rs_count", dut.wdog_q, 2);
      #1 reset = 1'b0;
      #1 chk("rs_out_valid", out_valid, 0);
      chk("rs_stall", stall, 0);
      chk("rs_err", err, 0);
      chk("rs_count_zero", dut.wdog_q, 0);
      chk("rs_out_data", out_data, 0);
      we = 0;
      tick();
      reset = 1'b1;
      tick();
      chk("post_rs_stall", stall, 0);
      chk("post_rs_valid", out_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
